// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and
// writeback, with optional addi/j/bne support and an optional memory-ready stall handshake.
module multicycle_controller #(
  parameter bit SUPPORT_ADDI  = 1'b1,
  parameter bit SUPPORT_J     = 1'b1,
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic [2:0] alucont,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  state_e state_q, state_d;
  aluop_e aluop;
  logic   ready;
  logic   op_legal;
  logic   taken;
  logic   pcwrite;
  logic   branch;
  logic   fetch_wr;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign taken = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ: op_legal = 1'b1;
      OP_BNE:  op_legal = SUPPORT_BNE;
      OP_ADDI: op_legal = SUPPORT_ADDI;
      OP_J:    op_legal = SUPPORT_J;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = ready ? DECODE : FETCH;
      DECODE: begin
        if (op_legal) begin
          case (op)
            OP_LW, OP_SW:   state_d = MEMADR;
            OP_RTYPE:       state_d = EXEC;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_ADDI:        state_d = ADDIEX;
            OP_J:           state_d = JUMP;
            default:        state_d = FETCH;
          endcase
        end
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = ready ? MEMWB : MEMRD;
      MEMWR:  state_d = ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      // single-step states and the unused encodings 12-15 all return to FETCH
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    memtoreg = 1'b0;
    regdst   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    memwrite = 1'b0;
    regwrite = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    fetch_wr = 1'b0;
    illegal  = 1'b0;
    aluop    = ALU_ADD;
    case (state_q)
      FETCH:  begin alusrcb = 2'b01; fetch_wr = ready; end
      DECODE: begin alusrcb = 2'b11; illegal = ~op_legal; end
      MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:  iord = 1'b1;
      MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      EXEC:   begin alusrca = 1'b1; aluop = ALU_FUNCT; end
      ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
      BRANCH: begin alusrca = 1'b1; aluop = ALU_SUB; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB: regwrite = 1'b1;
      JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end

  // reset only holds state_q at FETCH; the ready-qualified FETCH strobes need explicit gating
  assign irwrite = ~reset & fetch_wr;
  assign pcen    = ~reset & (fetch_wr | pcwrite | (branch & taken));

  always_comb begin
    alucont = 3'b010;
    case (aluop)
      ALU_SUB: alucont = 3'b110;
      ALU_FUNCT: begin
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b010;
        endcase
      end
      default: alucont = 3'b010;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction state paths and per-state
// control values are predicted from the instruction set rules and compared every cycle.
module tb_multicycle_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       sel;

  always #5 clk = ~clk;

  logic       a_memtoreg, a_regdst, a_iord, a_alusrca, a_irwrite, a_memwrite, a_regwrite, a_pcen, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [2:0] a_alucont;
  logic [3:0] a_state;
  logic       b_memtoreg, b_regdst, b_iord, b_alusrca, b_irwrite, b_memwrite, b_regwrite, b_pcen, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [2:0] b_alucont;
  logic [3:0] b_state;

  multicycle_controller dut (
    .clk(clk), .reset(rst_a), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memtoreg(a_memtoreg), .regdst(a_regdst), .iord(a_iord), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .irwrite(a_irwrite), .memwrite(a_memwrite),
    .regwrite(a_regwrite), .pcen(a_pcen), .alucont(a_alucont), .illegal(a_illegal),
    .state(a_state)
  );

  multicycle_controller #(
    .SUPPORT_ADDI(1'b0), .SUPPORT_J(1'b0), .SUPPORT_BNE(1'b0), .MEM_HANDSHAKE(1'b0)
  ) dut_min (
    .clk(clk), .reset(rst_b), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memtoreg(b_memtoreg), .regdst(b_regdst), .iord(b_iord), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .irwrite(b_irwrite), .memwrite(b_memwrite),
    .regwrite(b_regwrite), .pcen(b_pcen), .alucont(b_alucont), .illegal(b_illegal),
    .state(b_state)
  );

  logic [19:0] obs;
  always_comb begin
    obs = '0;
    if (sel)
      obs = {b_memtoreg, b_regdst, b_iord, b_alusrca, b_alusrcb, b_pcsrc, b_irwrite, b_memwrite,
             b_regwrite, b_pcen, b_alucont, b_illegal, b_state};
    else
      obs = {a_memtoreg, a_regdst, a_iord, a_alusrca, a_alusrcb, a_pcsrc, a_irwrite, a_memwrite,
             a_regwrite, a_pcen, a_alucont, a_illegal, a_state};
  end

  bit          m_addi, m_j, m_bne, m_hs;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word for one cycle spent in state s.
  function automatic logic [19:0] expect_ctrl(input int unsigned s, input logic rdy, input logic z,
                                              input logic legal, input logic isb,
                                              input logic [5:0] f, input logic in_rst);
    logic m2r, rd, io, asa, irw, mw, rw, pce, ill;
    logic [1:0] asb, pcs;
    logic [2:0] ac;
    {m2r, rd, io, asa, irw, mw, rw, pce, ill} = '0;
    asb = 2'b00;
    pcs = 2'b00;
    ac  = 3'b010;
    case (s)
      0:  begin asb = 2'b01; irw = rdy; pce = rdy; end
      1:  begin asb = 2'b11; ill = ~legal; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  io = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; ac = funct_alu(f); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; pce = isb ? ~z : z; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      11: begin pcs = 2'b10; pce = 1'b1; end
      default: ;
    endcase
    if (in_rst) {irw, mw, rw, pce, ill} = '0;
    return {m2r, rd, io, asa, asb, pcs, irw, mw, rw, pce, ac, ill, 4'(s)};
  endfunction

  function automatic logic op_is_legal(input logic [5:0] o);
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ: return 1'b1;
      OP_BNE:  return m_bne;
      OP_ADDI: return m_addi;
      OP_J:    return m_j;
      default: return 1'b0;
    endcase
  endfunction

  // zmode: 0/1 fixed zero flag, 2 random. stall < 0: random mem_ready; otherwise that many
  // not-ready cycles in the data-memory state and ready everywhere else.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode, input int stall);
    int unsigned path[5];
    int unsigned plen, idx;
    int          waits, streak;
    logic        legal, isb, rdy;
    legal = op_is_legal(iop);
    isb   = m_bne && (iop == OP_BNE);
    path  = '{0, 1, 0, 0, 0};
    plen  = 2;
    if (legal) begin
      case (iop)
        OP_LW:   begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
        OP_SW:   begin path[2] = 2; path[3] = 5; plen = 4; end
        OP_RTYPE: begin path[2] = 6; path[3] = 7; plen = 4; end
        OP_BEQ, OP_BNE: begin path[2] = 8; plen = 3; end
        OP_ADDI: begin path[2] = 9; path[3] = 10; plen = 4; end
        OP_J:    begin path[2] = 11; plen = 3; end
        default: ;
      endcase
    end
    op     = iop;
    funct  = ifn;
    idx    = 0;
    waits  = 0;
    streak = 0;
    while (idx < plen) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode != 0);
      if (stall < 0)
        mem_ready = (streak >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else
        mem_ready = (path[idx] == 3 || path[idx] == 5) ? (waits >= stall) : 1'b1;
      rdy = m_hs ? mem_ready : 1'b1;
      #1;
      check($sformatf("op%02h st%0d", iop, path[idx]), obs,
            expect_ctrl(path[idx], rdy, zero, legal, isb, ifn, 1'b0));
      if ((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !rdy) begin
        streak++;
        if (path[idx] != 0) waits++;
      end else begin
        idx++;
        streak = 0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // sw interrupted by reset while MEMWR is waiting on the memory.
  task automatic sw_reset_test();
    int unsigned sp[4];
    sp    = '{0, 1, 2, 5};
    op    = OP_SW;
    funct = 6'd0;
    zero  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (sp[i] != 5);
      #1;
      check($sformatf("swrst st%0d", sp[i]), obs,
            expect_ctrl(sp[i], mem_ready, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0));
      if (sp[i] != 5) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    rst_a = 1'b1;
    #1;
    check("swrst async", obs, expect_ctrl(0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1));
    @(posedge clk);
    #1;
    check("swrst held", obs, expect_ctrl(0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1));
    rst_a = 1'b0;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_RTYPE;
      3: return OP_BEQ;
      4: return OP_BNE;
      5: return OP_ADDI;
      6: return OP_J;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sel = 1'b0;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    m_addi = 1'b1;
    m_j = 1'b1;
    m_bne = 1'b1;
    m_hs = 1'b1;

    @(posedge clk);
    #1;
    check("reset full", obs, expect_ctrl(0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1));
    sel = 1'b1;
    #1;
    check("reset min", obs, expect_ctrl(0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1));
    sel = 1'b0;
    rst_a = 1'b0;

    run_instr(OP_LW, 6'd0, 2, 2);
    run_instr(OP_RTYPE, 6'b101010, 2, 0);
    run_instr(OP_BEQ, 6'd0, 1, 0);
    run_instr(OP_BEQ, 6'd0, 0, 0);
    run_instr(OP_BNE, 6'd0, 0, 0);
    run_instr(OP_BNE, 6'd0, 1, 0);
    run_instr(OP_J, 6'd0, 2, 0);
    run_instr(OP_ADDI, 6'd0, 2, 0);
    run_instr(OP_SW, 6'd0, 2, 1);
    run_instr(6'b111111, 6'd0, 2, 0);
    run_instr(OP_RTYPE, 6'b100000, 2, 0);
    run_instr(OP_RTYPE, 6'b100010, 2, 0);
    run_instr(OP_RTYPE, 6'b100100, 2, 0);
    run_instr(OP_RTYPE, 6'b100101, 2, 0);
    run_instr(OP_RTYPE, 6'b111111, 2, 0);
    sw_reset_test();
    for (int i = 0; i < 150; i++) run_instr(pick_op(), pick_funct(), 2, -1);

    sel = 1'b1;
    rst_a = 1'b1;
    m_addi = 1'b0;
    m_j = 1'b0;
    m_bne = 1'b0;
    m_hs = 1'b0;
    rst_b = 1'b0;
    run_instr(OP_J, 6'd0, 2, -1);
    run_instr(OP_ADDI, 6'd0, 2, -1);
    run_instr(OP_BNE, 6'd0, 0, -1);
    run_instr(OP_BEQ, 6'd0, 1, -1);
    run_instr(OP_LW, 6'd0, 2, -1);
    run_instr(OP_SW, 6'd0, 2, -1);
    for (int i = 0; i < 60; i++) run_instr(pick_op(), pick_funct(), 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle MIPS control unit that replaces the single-cycle controller when the datapath moves to a shared instruction/data memory and a multi-cycle ALU schedule. A registered Moore FSM sequences fetch, decode, execute, memory and writeback, optionally stalling on a memory-ready handshake. It drives the multicycle datapath's muxes and enables, and embeds the same main/ALU decode semantics, extended with optional `addi`, `j` and `bne`.

## Interface
- `SUPPORT_ADDI`, 1: enables the `addi` path (states ADDIEX/ADDIWB). When 0, opcode 001000 is illegal.
- `SUPPORT_J`, 1: enables the `j` path (state JUMP). When 0, opcode 000010 is illegal.
- `SUPPORT_BNE`, 1: enables `bne` (opcode 000101) in state BRANCH. When 0, that opcode is illegal.
- `MEM_HANDSHAKE`, 1: when 1, memory states wait for `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `clk` in 1: single clock. All state updates occur on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op` in 6: instruction opcode, taken from the instruction register.
- `funct` in 6: R-type function field.
- `zero` in 1: ALU zero flag, used during BRANCH.
- `mem_ready` in 1: memory access completes this cycle.
- `memtoreg` out 1: writeback data select. 1 selects the data register.
- `regdst` out 1: destination register select. 1 selects rd.
- `iord` out 1: memory address select. 1 selects ALUOut.
- `alusrca` out 1: ALU A select. 1 selects register A.
- `alusrcb` out 2: ALU B select. 00 = B, 01 = constant 4, 10 = signext, 11 = signext<<2.
- `pcsrc` out 2: next-PC select. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `irwrite` out 1: instruction register enable.
- `memwrite` out 1: memory write enable.
- `regwrite` out 1: register file write enable.
- `pcen` out 1: PC enable, equal to `pcwrite | (branch & taken)`.
- `alucont` out 3: ALU operation.
- `illegal` out 1: one-cycle pulse, asserted in DECODE when the opcode is unsupported.
- `state` out 4: current state encoding, for debug.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
  - Encodings 12–15 are unreachable. If entered, they go to FETCH with all enables 0.
- FETCH: drives `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, aluop add.
  - `irwrite` and `pcwrite` assert only when the memory is ready.
  - Moves to DECODE when ready; otherwise stays in FETCH.
- DECODE: drives `alusrcb`=11 and aluop add (branch target into ALUOut). Next state by opcode:
  - 100011 (`lw`) / 101011 (`sw`) → MEMADR.
  - 000000 → EXEC.
  - 000100 (`beq`), or 000101 (`bne`) if enabled → BRANCH.
  - 001000 (`addi`), if enabled → ADDIEX.
  - 000010 (`j`), if enabled → JUMP.
  - Any other opcode → FETCH with `illegal`=1.
- MEMADR: drives `alusrca`=1, `alusrcb`=10, aluop add. Goes to MEMRD for `lw`, MEMWR for `sw`.
- MEMRD: drives `iord`=1. Waits for ready, then goes to MEMWB.
- MEMWB: drives `regdst`=0, `memtoreg`=1, `regwrite`=1. Goes to FETCH.
- MEMWR: drives `iord`=1 and `memwrite`=1.
  - `memwrite` stays high for every wait cycle.
  - Goes to FETCH on ready.
- EXEC: drives `alusrca`=1, `alusrcb`=00, aluop funct. Goes to ALUWB.
- ALUWB: drives `regdst`=1, `memtoreg`=0, `regwrite`=1. Goes to FETCH.
- BRANCH: drives `alusrca`=1, `alusrcb`=00, aluop sub, `pcsrc`=01, branch=1.
  - Taken condition: `zero` for `beq`, `~zero` for `bne`.
  - Goes to FETCH.
- ADDIEX: drives `alusrca`=1, `alusrcb`=10, aluop add. Goes to ADDIWB.
- ADDIWB: drives `regdst`=0, `memtoreg`=0, `regwrite`=1. Goes to FETCH.
- JUMP: drives `pcsrc`=10 and `pcwrite`=1. Goes to FETCH.
- ALU control:
  - aluop add gives `alucont`=010; aluop sub gives 110.
  - aluop funct decodes `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Any other `funct` gives 010.
- Outputs not listed for a state are 0. Mux selects are 00/0.

## Timing
- Outputs are decoded combinationally from `state`. Exceptions: `pcen`/`illegal` also depend on `zero`/`op`, `alucont` also depends on `funct`, and in FETCH `irwrite`/`pcen` also depend on `mem_ready`.
- Minimum cycles per instruction with zero wait states: `lw` 5, `sw` 4, R-type 4, `addi` 4, `beq`/`bne` 3, `j` 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Other states ignore `mem_ready`.
- Reset:
  - Asserting `reset` forces `state`=FETCH asynchronously.
  - While `reset`=1, `irwrite`, `pcen`, `memwrite`, `regwrite` and `illegal` are forced to 0. Other outputs take their FETCH values.
  - The first FETCH access begins on the first rising edge after `reset` deasserts.
- Reset mid-instruction, including during a wait state, abandons the instruction with no further write enables asserted.

## Test plan
- Reset, then release with `mem_ready`=1: `state` sequences 0→1 on the first edge. All enables are 0 during reset; `irwrite`=`pcen`=1 in the first FETCH cycle.
- `lw` (op 100011), with `mem_ready` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. `regwrite`=1 and `memtoreg`=1 only in state 4.
- R-type `slt` (funct 101010): `alucont`=111 in EXEC. `regwrite`=1 and `regdst`=1 in ALUWB. Total 4 cycles.
- `beq` with `zero`=1 → `pcen`=1 and `pcsrc`=01 in BRANCH. Same instruction with `zero`=0 → `pcen`=0. `bne` with `zero`=0 → `pcen`=1.
- With `SUPPORT_J`=0, op 000010: `illegal`=1 for one cycle in DECODE, next state FETCH, no write enables. With `SUPPORT_J`=1: JUMP, `pcsrc`=10, `pcen`=1.
- `sw` with `reset` asserted during a MEMWR wait cycle: `memwrite` drops to 0 immediately and `state`=0.
